// File: rtl/sfifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package sfifo_uart_pkg;

  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] i_byte);
    return ^i_byte;
  endfunction

endpackage

// File: rtl/sfifo_uart_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module sfifo_uart_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running bit timer; held at zero while clear is asserted so a frame starts on a fresh bit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_done = (r_cnt == LAST);

endmodule

// File: rtl/sfifo_uart_tx.sv
// Pops bytes from the synchronous FIFO and sends each as a UART frame on txd.
//
//   state  | meaning
//   IDLE   | line at mark, waiting for enable and a non-empty FIFO
//   POP    | one-cycle FIFO read strobe
//   LOAD   | FIFO output now valid; capture byte and parity
//   START  | start bit (0)
//   DATA   | 8 data bits, LSB first
//   PARITY | even-parity bit (only when PARITY_EN)
//   STOP   | stop bit (1); last cycle decides between POP and IDLE
module sfifo_uart_tx
  import sfifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              txd,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [2:0]        r_bit_idx;
  logic              w_bit_done;
  logic              w_clear;
  logic              w_start_ok;

  // fifo_empty is only looked at where w_start_ok is consumed: IDLE and the last STOP cycle.
  assign w_start_ok = enable && !fifo_empty;
  assign w_clear    = (r_state == ST_IDLE) || (r_state == ST_POP) || (r_state == ST_LOAD);

  sfifo_uart_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clear   (w_clear),
    .bit_done(w_bit_done)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_POP;
      ST_POP:    w_next = ST_LOAD;
      ST_LOAD:   w_next = ST_START;
      ST_START:  if (w_bit_done) w_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_done && (r_bit_idx == 3'(DATA_W - 1))) begin
          w_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_bit_done) w_next = ST_STOP;
      ST_STOP: begin
        if (w_bit_done) begin
          w_next = w_start_ok ? ST_POP : ST_IDLE;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Byte capture one cycle after the read strobe, then shift out LSB first.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_bit_idx <= '0;
    end else if (r_state == ST_LOAD) begin
      r_shift   <= fifo_data;
      r_parity  <= even_parity(fifo_data);
      r_bit_idx <= '0;
    end else if ((r_state == ST_DATA) && w_bit_done) begin
      r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  // Outputs decoded from registered state only, so reset forces txd high at once.
  always_comb begin
    txd     = 1'b1;
    fifo_rd = 1'b0;
    busy    = 1'b1;
    case (r_state)
      ST_IDLE:   busy    = 1'b0;
      ST_POP:    fifo_rd = 1'b1;
      ST_START:  txd     = 1'b0;
      ST_DATA:   txd     = r_shift[0];
      ST_PARITY: txd     = r_parity;
      default:   ;
    endcase
  end

endmodule

// File: doc/sfifo_uart_tx.md
# sfifo_uart_tx

Downstream consumer of the team's 16×8 synchronous FIFO: pops bytes whenever the FIFO is non-empty and serializes each as an asynchronous UART frame on `txd`: start bit, 8 data bits LSB first, optional even parity, one stop bit. It drives the FIFO `read` strobe directly and captures the FIFO's registered output one cycle later. The FIFO does not guard reads when empty, so this block must never pop while `fifo_empty` is high.

## Interface
- `CLKS_PER_BIT`, default 16: CLK cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between D7 and stop.
- `CLK`  in  1: clock, all state on rising edge.
- `RSTn`  in  1: asynchronous, active-low reset.
- `enable`  in  1: permits starting new frames; does not abort a frame in flight.
- `fifo_empty`  in  1: FIFO `empty` flag.
- `fifo_data`  in  8: FIFO `oData`, valid the cycle after `fifo_rd`.
- `fifo_rd`  out  1: FIFO `read` strobe, single-cycle pulse per byte.
- `txd`  out  1: serial output, idle/mark = 1.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- IDLE: `txd`=1. Go to POP when `enable && !fifo_empty`.
- POP: `fifo_rd`=1 for exactly this cycle. Always go to LOAD.
- LOAD: capture `fifo_data` into the 8-bit shift register and compute parity = XOR of the 8 bits. Go to START.
- START: `txd`=0 for CLKS_PER_BIT cycles.
- DATA: `txd`=shift[0] for CLKS_PER_BIT cycles per bit, shift right, 8 bits tracked by a 3-bit index. Then go to PARITY if PARITY_EN, else STOP.
- PARITY: `txd`=parity bit for CLKS_PER_BIT cycles.
- STOP: `txd`=1 for CLKS_PER_BIT cycles. On the last cycle, go to POP if `enable && !fifo_empty`, else IDLE.
- `fifo_empty` is sampled only in IDLE and on the last STOP cycle. Changes at any other time are ignored.
- `enable` falling mid-frame: the current frame completes and no further pop occurs.
- Bit counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.

## Timing
- Reset values: `txd`=1, `fifo_rd`=0, `busy`=0; state IDLE, counters 0, shift register 0x00.
- Reset asserted mid-frame: `txd` returns to 1 asynchronously. A byte already popped is discarded and not retried.
- `txd`, `fifo_rd` and `busy` are registered or decoded from registered state only; no combinational path from inputs.
- Latency: `fifo_empty` low in IDLE at edge N → `fifo_rd` high in cycle N+1 → `txd` falls at cycle N+3.
- Frame length: (10 + PARITY_EN) × CLKS_PER_BIT cycles, from START entry to STOP exit.
- Back-to-back frames: exactly 2 mark cycles (POP, LOAD) between stop-bit end and the next start bit.
- `busy` rises on entry to POP and falls on re-entry to IDLE.

## Structure
- Package `sfifo_uart_pkg` holds:
  - the state enum (7 states, 3-bit encoding);
  - `DATA_W`=8, `STOP_BITS`=1;
  - helper function `even_parity(byte)`.
- Sub-module `sfifo_uart_baud`: bit-period counter with `clear` input and `bit_done` output (high on count CLKS_PER_BIT-1). The FSM, shift register and FIFO handshake stay in the top module.

## Test plan
- CLKS_PER_BIT=4, PARITY_EN=0; push 0xA5 into the FIFO, then hold `enable`=1 → one `fifo_rd` pulse. `txd` holds 4 cycles each of 0,1,0,1,0,0,1,0,1,1, then stays 1; `busy` falls.
- FIFO empty, `enable`=1, run 200 cycles → `fifo_rd` never asserts, `txd`=1, `busy`=0.
- Push 0x00 then 0xFF → two frames with exactly 2 mark cycles between the first stop end and the second start; FIFO `empty` is 1 after the second pop.
- PARITY_EN=1, send 0x07 → parity bit is 1. Send 0x03 → parity bit is 0. Frame length is 44 cycles.
- Reset asserted during the DATA state of byte 0x3C → `txd`=1 immediately. After release, no frame is sent until the FIFO holds new data.
- Load 3 bytes, then drop `enable` during the first frame's DATA state → only the first frame is sent; 2 bytes remain in the FIFO.
